// File: rtl/pe_feeder.sv
// Operand feeder for a MAC PE: buffers (a,b) pairs in a FIFO and streams KLEN-term vectors,
// then drains, flags the result and clears the accumulator. Optional macro: PE_FEEDER_STALL_CNT_EN.
module pe_feeder #(
    parameter int DEPTH = 4,
    parameter int KLEN  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [31:0] pe_a,
    output logic [31:0] pe_b,
    output logic        pe_clr,
    output logic        res_valid
`ifdef PE_FEEDER_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int KW = (KLEN > 1) ? $clog2(KLEN) : 1;

    typedef enum logic [2:0] {
        IDLE,
        FEED,
        DRAIN1,
        DRAIN2,
        CLEAR
    } state_e;

    state_e        state_q, state_d;
    logic [KW-1:0] kcnt_q, kcnt_d;

    logic [31:0]   mem_a_q [DEPTH];
    logic [31:0]   mem_b_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          full, empty, push, pop;

    logic [31:0]   pe_a_q, pe_a_d, pe_b_q, pe_b_d;
    logic          pe_clr_q, pe_clr_d, res_valid_q, res_valid_d;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign in_ready = !full;
    assign push     = in_valid && !full;

    // Storage is left unreset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a_q[wr_ptr_q] <= in_a;
            mem_b_q[wr_ptr_q] <= in_b;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!empty) state_d = FEED;
            FEED:    if (pop && (kcnt_q == KW'(KLEN - 1))) state_d = DRAIN1;
            DRAIN1:  state_d = DRAIN2;
            DRAIN2:  state_d = CLEAR;
            CLEAR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Only FEED pops; every other state presents zero operands to the PE.
    always_comb begin
        pop         = (state_q == FEED) && !empty;
        kcnt_d      = kcnt_q;
        pe_a_d      = '0;
        pe_b_d      = '0;
        res_valid_d = (state_q == DRAIN2);
        pe_clr_d    = (state_q == CLEAR);
        if (state_q == IDLE) begin
            kcnt_d = '0;
        end
        if (pop) begin
            pe_a_d = mem_a_q[rd_ptr_q];
            pe_b_d = mem_b_q[rd_ptr_q];
            kcnt_d = kcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kcnt_q      <= '0;
            pe_a_q      <= '0;
            pe_b_q      <= '0;
            pe_clr_q    <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            kcnt_q      <= kcnt_d;
            pe_a_q      <= pe_a_d;
            pe_b_q      <= pe_b_d;
            pe_clr_q    <= pe_clr_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign pe_a      = pe_a_q;
    assign pe_b      = pe_b_q;
    assign pe_clr    = pe_clr_q;
    assign res_valid = res_valid_q;

`ifdef PE_FEEDER_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == CLEAR) begin
            stall_d = '0;
        end else if ((state_q == FEED) && empty && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_pe_feeder.sv
// Randomized bench for pe_feeder with a queue-based reference model and an emulated MAC PE.
module tb_pe_feeder;

    localparam int DEPTH = 4;
    localparam int KLEN  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        in_ready;
    logic [31:0] pe_a, pe_b;
    logic        pe_clr, res_valid;
`ifdef PE_FEEDER_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    pe_feeder #(.DEPTH(DEPTH), .KLEN(KLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .pe_a      (pe_a),
        .pe_b      (pe_b),
        .pe_clr    (pe_clr),
        .res_valid (res_valid)
`ifdef PE_FEEDER_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
    } pair_t;

    // Reference model: pairs accepted but not yet seen at the PE, plus per-vector bookkeeping.
    pair_t       fifo_m[$];
    int          k_m = 0;
    int          bub_m = 0;
    int          exp_bub = 0;
    logic [31:0] sum_m = '0;
    logic [31:0] exp_sum = '0;
    logic [31:0] pe_acc = '0;
    logic [31:0] sums_seen[$];
    longint      cyc = 0;
    longint      rv_due = -1;
    longint      clr_due = -1;
    longint      last_end = -100;
    logic        expect_pop = 1'b0;
    int          vec_done = 0;
    int          ready_low = 0;

    initial begin : monitor
        logic  got;
        pair_t e;
        pair_t p;
        int    occ;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                check("rst_res_valid", res_valid, 0);
                check("rst_pe_clr", pe_clr, 0);
                check("rst_in_ready", in_ready, 1);
                fifo_m.delete();
                k_m = 0; bub_m = 0; sum_m = '0; pe_acc = '0;
                rv_due = -1; clr_due = -1; last_end = -100; expect_pop = 1'b0;
            end else begin
                got = (pe_a != 0) || (pe_b != 0);
                if (expect_pop) check("pop_when_nonempty", got, 1);
                if (got) begin
                    if (fifo_m.size() == 0) begin
                        check("spurious_pair", 1, 0);
                    end else begin
                        e = fifo_m.pop_front();
                        check("pe_a", pe_a, e.a);
                        check("pe_b", pe_b, e.b);
                        if (k_m == 0) check("vector_gap_ok", (cyc - last_end) >= 5, 1);
                        sum_m = sum_m + e.a * e.b;
                        k_m++;
                        if (k_m == KLEN) begin
                            last_end = cyc; rv_due = cyc + 2; clr_due = cyc + 3;
                            exp_sum = sum_m; exp_bub = bub_m;
                            k_m = 0; sum_m = '0; bub_m = 0;
                        end
                    end
                end
                check("res_valid", res_valid, cyc == rv_due);
                if (res_valid) begin
                    check("pe_sum", pe_acc, exp_sum);
                    sums_seen.push_back(pe_acc);
`ifdef PE_FEEDER_STALL_CNT_EN
                    check("stall_cnt", stall_cnt, exp_bub);
`endif
                    vec_done++;
                end
                check("pe_clr", pe_clr, cyc == clr_due);
                occ = fifo_m.size();
                check("in_ready", in_ready, occ < DEPTH);
                expect_pop = (k_m > 0) && (occ > 0);
                if (k_m > 0 && occ == 0) bub_m++;
                pe_acc = pe_clr ? 32'd0 : pe_acc + pe_a * pe_b;
                if (in_valid && in_ready) begin
                    p.a = in_a; p.b = in_b;
                    fifo_m.push_back(p);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b);
        logic acc;
        int   t;
        t = 0;
        in_valid = 1'b1; in_a = a; in_b = b;
        do begin
            @(negedge clk);
            acc = in_ready;
            if (!acc) ready_low++;
            @(posedge clk);
            #1;
            t++;
        end while (!acc && t < 200);
        if (!acc) check("push_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_vec(input int target);
        for (int i = 0; i < 600 && vec_done < target; i++) @(posedge clk);
        #1;
        if (vec_done < target) check("vec_timeout", vec_done, target);
    endtask

    function automatic logic [31:0] rnd_op();
        logic [31:0] v;
        v = $urandom;
        if (v == 0) v = 32'd1;
        return v;
    endfunction

    initial begin : stim
        int vd;
        repeat (3) @(posedge clk);
        #1;
        check("reset_pe_a", pe_a, 0);
        check("reset_pe_b", pe_b, 0);
        check("reset_pe_clr", pe_clr, 0);
        check("reset_res_valid", res_valid, 0);
        check("reset_in_ready", in_ready, 1);
        rst_n = 1'b1;
        idle(2);

        push(1, 2); push(3, 4); push(5, 6); push(7, 8);
        wait_vec(1);
        check("basic_sum", sums_seen[0], 100);

        for (int i = 0; i < 12; i++) push(32'd100 + i, 32'd3);
        check("fifo_filled", ready_low > 0, 1);
        wait_vec(4);

        for (int i = 0; i < 8; i++) begin
            push(i + 1, 5);
            idle(2);
        end
        wait_vec(6);

        for (int i = 0; i < 24; i++) begin
            push(rnd_op(), rnd_op());
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        wait_vec(12);
        idle(4);

        vd = vec_done;
        push(11, 1); push(12, 1);
        for (int i = 0; i < 50 && k_m < 2; i++) @(posedge clk);
        #1;
        check("partial_issued", k_m, 2);
        rst_n = 1'b0;
        #1;
        check("async_rst_pe_a", pe_a, 0);
        check("async_rst_pe_b", pe_b, 0);
        check("async_rst_in_ready", in_ready, 1);
        check("async_rst_res_valid", res_valid, 0);
        idle(2);
        rst_n = 1'b1;
        idle(8);
        check("no_result_after_rst", vec_done, vd);
        for (int i = 0; i < 4; i++) push(2, 3);
        wait_vec(vd + 1);
        check("post_rst_sum", sums_seen[$], 24);

        vd = vec_done;
        for (int i = 0; i < 4; i++) push(1, 1);
        for (int i = 0; i < 4; i++) push(2, 2);
        wait_vec(vd + 2);
        check("b2b_sum_first", sums_seen[vd], 4);
        check("b2b_sum_second", sums_seen[vd + 1], 16);

        push(32'hFFFF_FFFF, 32'h2);
        for (int i = 0; i < 3; i++) push(1, 1);
        wait_vec(vd + 3);
        check("wrap_sum", sums_seen[vd + 2], 1);

        idle(10);
        check("model_drained", fifo_m.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pe_feeder.md
PE_FEEDER -- requirements
Module: pe_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, operand FIFO depth in entries (power of two, >=2).
REQ-002 SHALL have parameter KLEN, default 8, number of operand pairs per dot product (2..256).
REQ-003 SHALL have port clk  input  1  the single clock; all state on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  upstream operand pair valid.
REQ-006 SHALL have port in_ready  output  1  FIFO can accept a pair.
REQ-007 SHALL have ports in_a, in_b  input  32 each  operand pair.
REQ-008 SHALL have ports pe_a, pe_b  output  32 each  registered operands driven to the downstream MAC PE.
REQ-009 SHALL have port pe_clr  output  1  registered, active-high, one-cycle clear request for the PE accumulator.
REQ-010 SHALL have port res_valid  output  1  registered; high in the one cycle the PE accumulator holds a complete KLEN-term sum.

Function
REQ-011 SHALL accept a pair into the FIFO on any rising edge with in_valid && in_ready.
REQ-012 SHALL drive in_ready = !full, combinationally from FIFO occupancy only, never from in_valid.
REQ-013 SHALL, when full, hold in_ready low and not overwrite any entry.
REQ-014 SHALL wrap FIFO read/write pointers modulo DEPTH without loss or duplication.
REQ-015 SHALL implement states IDLE, FEED, DRAIN1, DRAIN2, CLEAR.
REQ-016 SHALL go IDLE->FEED when the FIFO is non-empty; kcnt cleared to 0.
REQ-017 SHALL, in FEED with FIFO non-empty, pop one pair, register it onto pe_a/pe_b, and increment kcnt.
REQ-018 SHALL, in FEED with FIFO empty, drive pe_a = pe_b = 0 (bubble), not increment kcnt, and stay in FEED.
REQ-019 SHALL go FEED->DRAIN1 on the edge that issues pair KLEN-1.
REQ-020 SHALL go DRAIN1->DRAIN2->CLEAR->IDLE unconditionally, one cycle each.
REQ-021 SHALL drive pe_a = pe_b = 0 in IDLE, DRAIN1, DRAIN2 and CLEAR.
REQ-022 SHALL not pop in DRAIN1, DRAIN2 or CLEAR, while continuing to accept pushes.
REQ-023 SHALL, if the last pair is on pe_a/pe_b in cycle n, assert res_valid in cycle n+2 (DRAIN2) and pe_clr in cycle n+3 (CLEAR), each for exactly one cycle.
REQ-024 SHALL, with a non-empty FIFO, issue the first pair of the next vector no earlier than cycle n+5.
REQ-025 SHALL, on a simultaneous push and pop, update occupancy by net zero and preserve FIFO order.

Reset
REQ-026 SHALL, on rst_n low, asynchronously set state IDLE, kcnt 0, FIFO empty, pe_a = pe_b = 0, pe_clr = 0, res_valid = 0, in_ready = 1.
REQ-027 SHALL discard all buffered pairs and any partial dot product on a reset mid-operation, with no res_valid pulse for it.
REQ-028 SHALL resume normal operation on the first rising edge after rst_n deasserts.

Configuration
REQ-029 SHALL, when PE_FEEDER_STALL_CNT_EN is defined, add port stall_cnt  output  16, counting FEED cycles with FIFO empty, saturating at 16'hFFFF, cleared on reset and in CLEAR.
REQ-030 SHALL, when PE_FEEDER_STALL_CNT_EN is undefined, omit the stall_cnt port and counter, with all other behaviour identical.

Verification
REQ-031 SHALL verify: KLEN=4; push (1,2),(3,4),(5,6),(7,8) back-to-back -> PE sum 100; res_valid one cycle, 2 cycles after the last pair; pe_clr the next cycle.
REQ-032 SHALL verify: DEPTH=4, no pops (FSM held in DRAIN/CLEAR window), push 5 pairs -> in_ready low after 4; 5th pair not accepted until a pop; order preserved.
REQ-033 SHALL verify: in_valid toggled 1,0,0,1... during FEED -> bubbles drive zeros, kcnt unchanged, final sum correct; stall_cnt equals the number of bubbles when the macro is defined.
REQ-034 SHALL verify: rst_n low after 2 of 4 pairs -> outputs at reset values immediately; FIFO empty; no res_valid; next full vector sums correctly.
REQ-035 SHALL verify: two vectors queued back-to-back, (1,1)x4 and (2,2)x4 -> res_valid twice with sums 4 then 16; gap >= 4 cycles between vectors; operands 32'hFFFF_FFFF x 32'h2 -> truncated 32-bit wrap.
